// File: rtl/round_sequencer_pkg.sv
// Shared game package: sequencer state encoding, default timing parameters
// and the two-bit hand result codes ({player_light, dealer_light}).
// Used by the hand state machine, the round sequencer and its bench.
package round_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_HOLD   = 3'd4
    } seq_state_t;

    localparam int CLEAR_CYC_DEF   = 2;
    localparam int TIMEOUT_CYC_DEF = 15;

    localparam int TALLY_W = 8;
    localparam int CNT_W   = 8;

    // Result codes are {player_win_light, dealer_win_light}
    localparam logic [1:0] RES_NONE   = 2'b00;
    localparam logic [1:0] RES_DEALER = 2'b01;
    localparam logic [1:0] RES_PLAYER = 2'b10;
    localparam logic [1:0] RES_TIE    = 2'b11;

endpackage

// File: rtl/round_sequencer_if.sv
// Round sequencer bus: start request and hand lights in, hand-machine
// reset, status flags and tallies out.
//   master : the side that presses start and reports lights (board / bench)
//   slave  : the round sequencer
interface round_sequencer_if import round_sequencer_pkg::*; ();

    logic               start;
    logic               player_win_light;
    logic               dealer_win_light;
    logic               game_rst;
    logic               busy;
    logic               round_done;
    logic               timeout_err;
    logic [TALLY_W-1:0] player_tally;
    logic [TALLY_W-1:0] dealer_tally;
    logic [TALLY_W-1:0] tie_tally;
    logic [TALLY_W-1:0] round_count;

    modport master (
        output start, player_win_light, dealer_win_light,
        input  game_rst, busy, round_done, timeout_err,
        input  player_tally, dealer_tally, tie_tally, round_count
    );

    modport slave (
        input  start, player_win_light, dealer_win_light,
        output game_rst, busy, round_done, timeout_err,
        output player_tally, dealer_tally, tie_tally, round_count
    );

endinterface

// File: rtl/round_sequencer_sat_counter.sv
// sat_counter: W-bit up counter with synchronous active-high clear and an
// increment enable; holds at all-ones instead of wrapping.
//   clk : clock
//   clr : synchronous clear, dominates inc
//   inc : increment enable
//   q   : count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (inc && (q != {W{1'b1}}))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: runs one baccarat round per start press.
// IDLE -> CLEAR (hold hand machine in reset) -> PLAY (wait for a light or
// time out) -> SETTLE (tally) -> HOLD (show result until start released).
//   slow_clock : sole clock
//   resetb     : synchronous active-high reset
//   bus        : start/lights in; game_rst, busy, round_done, timeout_err,
//                saturating tallies and wrapping round_count out
// Every output is a register; game_rst/busy/round_done are decoded from the
// next state so they change on the same edge as the state.
module round_sequencer import round_sequencer_pkg::*; #(
    parameter int CLEAR_CYC   = CLEAR_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             slow_clock,
    input  logic             resetb,
    round_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYC - 1);
    localparam logic [CNT_W-1:0] PLAY_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    seq_state_t         state, state_nxt;
    logic [CNT_W-1:0]   cyc_cnt, cyc_cnt_nxt;
    logic [1:0]         result, result_nxt;
    logic               tmo_hit;
    logic               settle_now;
    logic               lights_any;

    logic               game_rst_q, busy_q, round_done_q, timeout_err_q;
    logic [TALLY_W-1:0] round_count_q;
    logic [TALLY_W-1:0] player_q, dealer_q, tie_q;

    assign lights_any = bus.player_win_light | bus.dealer_win_light;

    always_comb begin
        state_nxt   = state;
        cyc_cnt_nxt = cyc_cnt;
        result_nxt  = result;
        tmo_hit     = 1'b0;
        settle_now  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt   = ST_CLEAR;
                    cyc_cnt_nxt = '0;
                    result_nxt  = RES_NONE;
                end
            end
            ST_CLEAR: begin
                if (cyc_cnt == CLEAR_LAST) begin
                    state_nxt   = ST_PLAY;
                    cyc_cnt_nxt = '0;
                end else begin
                    cyc_cnt_nxt = cyc_cnt + 1'b1;
                end
            end
            ST_PLAY: begin
                cyc_cnt_nxt = cyc_cnt + 1'b1;
                // A light on the last allowed cycle still counts as a result
                if (lights_any) begin
                    state_nxt  = ST_SETTLE;
                    result_nxt = {bus.player_win_light, bus.dealer_win_light};
                end else if (cyc_cnt == PLAY_LAST) begin
                    state_nxt = ST_HOLD;
                    tmo_hit   = 1'b1;
                end
            end
            ST_SETTLE: begin
                state_nxt  = ST_HOLD;
                settle_now = 1'b1;
            end
            ST_HOLD: begin
                // Only a released start re-arms IDLE, so a held button
                // cannot launch a second round
                if (!bus.start)
                    state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt   = ST_IDLE;
                cyc_cnt_nxt = '0;
                result_nxt  = RES_NONE;
            end
        endcase
    end

    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            state         <= ST_IDLE;
            cyc_cnt       <= '0;
            result        <= RES_NONE;
            game_rst_q    <= 1'b1;
            busy_q        <= 1'b0;
            round_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            round_count_q <= '0;
        end else begin
            state         <= state_nxt;
            cyc_cnt       <= cyc_cnt_nxt;
            result        <= result_nxt;
            game_rst_q    <= (state_nxt == ST_IDLE) || (state_nxt == ST_CLEAR);
            busy_q        <= (state_nxt != ST_IDLE);
            round_done_q  <= (state_nxt == ST_SETTLE);
            if (tmo_hit)
                timeout_err_q <= 1'b1;
            if (tmo_hit || settle_now)
                round_count_q <= round_count_q + 1'b1;
        end
    end

    sat_counter #(.W(TALLY_W)) u_player_tally (
        .clk (slow_clock),
        .clr (resetb),
        .inc (settle_now && (result == RES_PLAYER)),
        .q   (player_q)
    );

    sat_counter #(.W(TALLY_W)) u_dealer_tally (
        .clk (slow_clock),
        .clr (resetb),
        .inc (settle_now && (result == RES_DEALER)),
        .q   (dealer_q)
    );

    sat_counter #(.W(TALLY_W)) u_tie_tally (
        .clk (slow_clock),
        .clr (resetb),
        .inc (settle_now && (result == RES_TIE)),
        .q   (tie_q)
    );

    assign bus.game_rst     = game_rst_q;
    assign bus.busy         = busy_q;
    assign bus.round_done   = round_done_q;
    assign bus.timeout_err  = timeout_err_q;
    assign bus.round_count  = round_count_q;
    assign bus.player_tally = player_q;
    assign bus.dealer_tally = dealer_q;
    assign bus.tie_tally    = tie_q;

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 The module SHALL have these ports (clock and reset first):
- slow_clock  in  1  sole clock; all state changes on rising edge
- resetb  in  1  synchronous, active-high reset
- start  in  1  level request for a new round (debounced button)
- player_win_light  in  1  from the baccarat hand state machine
- dealer_win_light  in  1  from the baccarat hand state machine
- game_rst  out  1  active-high reset to the hand state machine and card/score datapath
- busy  out  1  high whenever the state is not IDLE
- round_done  out  1  one-cycle pulse when a round result is tallied
- timeout_err  out  1  sticky flag: a round exceeded TIMEOUT_CYC
- player_tally  out  8  player wins, saturating
- dealer_tally  out  8  dealer wins, saturating
- tie_tally  out  8  ties, saturating
- round_count  out  8  completed plus timed-out rounds, wraps modulo 256

REQ-002 The module SHALL have these parameters:
- CLEAR_CYC  default 2  number of cycles game_rst is held per round
- TIMEOUT_CYC  default 15  maximum PLAY cycles before abort

Function
REQ-003 States: IDLE, CLEAR, PLAY, SETTLE, HOLD. Encoding is free; there SHALL be no unreachable lock-up state, and any illegal encoding SHALL go to IDLE.
REQ-004 IDLE: game_rst=1 and busy=0. start=1 SHALL cause a transition to CLEAR on the next edge.
REQ-005 CLEAR: game_rst=1 for exactly CLEAR_CYC cycles, counted by a cycle counter cleared on entry; then the state SHALL go to PLAY.
REQ-006 PLAY: game_rst=0. The cycle counter SHALL increment each cycle. The first cycle with (player_win_light | dealer_win_light)=1 SHALL go to SETTLE, with both lights captured into a 2-bit result register on that same edge.
REQ-007 PLAY timeout: if the counter reaches TIMEOUT_CYC with both lights 0, the block SHALL:
- set timeout_err;
- increment round_count;
- leave all tallies unchanged;
- go to HOLD.
A light and a timeout in the same cycle SHALL resolve as a light (result wins).
REQ-008 SETTLE (one cycle): game_rst=0 and round_done=1. Tally update by captured result:
- 10: player_tally +1
- 01: dealer_tally +1
- 11: tie_tally +1
Then round_count SHALL increment and the state SHALL go to HOLD.
REQ-009 Tallies SHALL saturate at 255. round_count SHALL wrap from 255 to 0.
REQ-010 HOLD: game_rst=0, so the hand result stays displayed. The state SHALL stay in HOLD while start=1 and go to IDLE on the first cycle with start=0. This gives exactly one round per start assertion.
REQ-011 Lights SHALL be sampled only in PLAY; light activity in other states SHALL be ignored.
REQ-012 All outputs SHALL be registered. game_rst SHALL be a registered decode of the next state, so it changes on the same edge as the state.
REQ-013 start held continuously SHALL NOT auto-repeat rounds.

Reset
REQ-014 On resetb=1 at a clock edge, the following SHALL apply on the next cycle, regardless of current state (including mid-PLAY):
- state=IDLE;
- game_rst=1;
- busy=0, round_done=0, timeout_err=0;
- all tallies=0, round_count=0;
- counter and result register cleared.
REQ-015 timeout_err SHALL clear only on reset.

Structure
REQ-016 The state encoding, CLEAR_CYC and TIMEOUT_CYC defaults, and the result codes (10 player, 01 dealer, 11 tie) SHALL live in the shared game package, reused by the hand state machine and the top level.
REQ-017 A single sub-module sat_counter (8-bit, synchronous active-high clear, increment enable, saturate at max) SHALL be instantiated three times for the tallies. round_count and the cycle counter SHALL be inline.
REQ-018 The block SHALL use only slow_clock: no derived clocks and no combinational paths from inputs to outputs.

Verification
REQ-019 Player win: start=1 for 1 cycle, then the lights go 10 at PLAY cycle 5 -> game_rst high 2 cycles, round_done pulses once, player_tally=1, round_count=1, then IDLE.
REQ-020 Tie plus held start: start held for 30 cycles, lights 11 at PLAY cycle 4 -> tie_tally=1; the block stays in HOLD until start=0; exactly one round is counted.
REQ-021 Timeout: lights stay 00 -> after 15 PLAY cycles timeout_err=1, round_count=1, all tallies 0, no round_done.
REQ-022 Saturation/wrap: 260 dealer-win rounds -> dealer_tally=255, round_count=4.
REQ-023 Mid-round reset: resetb=1 at PLAY cycle 3 -> next cycle IDLE, game_rst=1, all counts 0, timeout_err=0.
REQ-024 Light/timeout collision: lights 01 on the TIMEOUT_CYC cycle -> dealer_tally=1, timeout_err stays 0.
